// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder
//   Turns completed PS/2 bytes (Scan Code Set 2) into key events. E0 (extended)
//   and F0 (break) prefixes are folded into flags, so one event is produced per
//   key press or release. Events wait in a show-ahead FIFO for the consumer, and
//   the receiver is held off through rx_en_o while that FIFO is full.
//
//   Ports
//     clk_i, rst_i        clock, synchronous active-high reset
//     rx_tick_i           one-cycle byte-ready strobe from the byte receiver
//     rx_data_i[7:0]      received scan code, valid with rx_tick_i
//     rx_start_i          captured frame start bit (0 for a good frame)
//     rx_en_o             receiver enable, low while the FIFO is full
//     evt_valid_o         FIFO holds at least one event
//     evt_ready_i         consumer pop request
//     evt_code_o[7:0]     head event scan code, prefixes removed
//     evt_ext_o           head event was E0-prefixed
//     evt_rel_o           head event is a release
//     evt_ascii_o[7:0]    ASCII of the head event (00 when not mapped)
//     frame_err_o         pulse: a byte was discarded as invalid
//     ovf_o               pulse: an event was lost to a full FIFO
//
//   Build option
//     PS2_ASCII_EN        when defined, evt_ascii_o carries a lookup of the head
//                         event; otherwise it is tied to 00.
module ps2_scan_decoder #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_tick_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_start_i,
  output logic       rx_en_o,
  output logic       evt_valid_o,
  input  logic       evt_ready_i,
  output logic [7:0] evt_code_o,
  output logic       evt_ext_o,
  output logic       evt_rel_o,
  output logic [7:0] evt_ascii_o,
  output logic       frame_err_o,
  output logic       ovf_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = ($clog2(TIMEOUT_CYC) > 17) ? $clog2(TIMEOUT_CYC) : 17;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            frame_err_q, ovf_q;

  logic            is_e0_s, is_f0_s, byte_bad_s, byte_ok_s, timeout_s;
  logic            push_s;
  logic [9:0]      push_ent_s;
  logic            empty_s, full_s, pop_s, wr_en_s;
  logic [9:0]      head_s;

`ifdef PS2_ASCII_EN
  function automatic logic [7:0] ascii_of(input logic [7:0] code);
    logic [7:0] a;
    case (code)
      8'h1C: a = 8'h41;  8'h32: a = 8'h42;  8'h21: a = 8'h43;  8'h23: a = 8'h44;
      8'h24: a = 8'h45;  8'h2B: a = 8'h46;  8'h34: a = 8'h47;  8'h33: a = 8'h48;
      8'h43: a = 8'h49;  8'h3B: a = 8'h4A;  8'h42: a = 8'h4B;  8'h4B: a = 8'h4C;
      8'h3A: a = 8'h4D;  8'h31: a = 8'h4E;  8'h44: a = 8'h4F;  8'h4D: a = 8'h50;
      8'h15: a = 8'h51;  8'h2D: a = 8'h52;  8'h1B: a = 8'h53;  8'h2C: a = 8'h54;
      8'h3C: a = 8'h55;  8'h2A: a = 8'h56;  8'h1D: a = 8'h57;  8'h22: a = 8'h58;
      8'h35: a = 8'h59;  8'h1A: a = 8'h5A;
      8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
      8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;  8'h46: a = 8'h39;
      8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
      default: a = 8'h00;
    endcase
    return a;
  endfunction
`endif

  // Byte classification and prefix-timeout detection.
  always_comb begin
    is_e0_s    = (rx_data_i == 8'hE0);
    is_f0_s    = (rx_data_i == 8'hF0);
    byte_bad_s = rx_tick_i && (rx_start_i || (rx_data_i == 8'h00) || (rx_data_i == 8'hFF));
    byte_ok_s  = rx_tick_i && !byte_bad_s;
    // A byte arriving on the expiry cycle still counts; timeout needs a quiet cycle.
    timeout_s  = !rx_tick_i && (state_q != S_IDLE) && (tmo_q == TMO_LAST);
  end

  // Prefix FSM: state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Prefix FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    if (byte_bad_s) begin
      state_d = S_IDLE;
    end else if (byte_ok_s) begin
      case (state_q)
        S_IDLE:    state_d = is_e0_s ? S_EXT : (is_f0_s ? S_BRK : S_IDLE);
        S_EXT:     state_d = is_f0_s ? S_EXT_BRK : (is_e0_s ? S_EXT : S_IDLE);
        S_BRK:     state_d = is_e0_s ? S_EXT_BRK : (is_f0_s ? S_BRK : S_IDLE);
        S_EXT_BRK: state_d = (is_e0_s || is_f0_s) ? S_EXT_BRK : S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end else if (timeout_s) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // Prefix FSM: outputs (event push and its flags).
  always_comb begin
    push_s     = byte_ok_s && !is_e0_s && !is_f0_s;
    push_ent_s = {(state_q == S_EXT) || (state_q == S_EXT_BRK),
                  (state_q == S_BRK) || (state_q == S_EXT_BRK),
                  rx_data_i};
  end

  // Timeout counter next value; runs only while a prefix is pending and idle.
  always_comb begin
    if (rx_tick_i || (state_q == S_IDLE) || timeout_s) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // FIFO control: a full FIFO still accepts a push when a pop frees a slot.
  always_comb begin
    empty_s = (cnt_q == '0);
    full_s  = (cnt_q == DEPTH_CNT);
    pop_s   = !empty_s && evt_ready_i;
    wr_en_s = push_s && (!full_s || pop_s);
    case ({wr_en_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Counter, FIFO pointers and registered pulse outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q       <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
      frame_err_q <= byte_bad_s;
      ovf_q       <= push_s && full_s && !pop_s;
      if (pop_s) begin
        rd_q <= rd_q + PW'(1);
      end
      if (wr_en_s) begin
        wr_q <= wr_q + PW'(1);
      end
    end
  end

  // FIFO storage; cleared on reset so the empty head reads as zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[wr_q] <= push_ent_s;
    end
  end

  assign head_s      = mem_q[rd_q];
  assign evt_valid_o = !empty_s;
  assign rx_en_o     = !full_s;
  assign evt_ext_o   = head_s[9];
  assign evt_rel_o   = head_s[8];
  assign evt_code_o  = head_s[7:0];
  assign frame_err_o = frame_err_q;
  assign ovf_o       = ovf_q;

`ifdef PS2_ASCII_EN
  assign evt_ascii_o = head_s[9] ? 8'h00 : ascii_of(head_s[7:0]);
`else
  assign evt_ascii_o = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scan_decoder.sv
module tb_ps2_scan_decoder;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_start = 1'b0;
  logic       evt_ready = 1'b0;
  logic       rx_en_o, evt_valid_o, evt_ext_o, evt_rel_o, frame_err_o, ovf_o;
  logic [7:0] evt_code_o, evt_ascii_o;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // behavioural model state
  logic [9:0] mq[$];
  bit m_ext = 1'b0, m_brk = 1'b0;
  int since = 0;
  bit exp_fe = 1'b0, exp_ovf = 1'b0;

  logic [7:0] pool [16] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                            8'h45, 8'h16, 8'h1E, 8'h29, 8'h5A, 8'h66, 8'h74, 8'h75};

  ps2_scan_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .rx_tick_i(rx_tick), .rx_data_i(rx_data),
    .rx_start_i(rx_start), .rx_en_o(rx_en_o), .evt_valid_o(evt_valid_o),
    .evt_ready_i(evt_ready), .evt_code_o(evt_code_o), .evt_ext_o(evt_ext_o),
    .evt_rel_o(evt_rel_o), .evt_ascii_o(evt_ascii_o), .frame_err_o(frame_err_o),
    .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_ascii(input logic [9:0] e);
`ifdef PS2_ASCII_EN
    logic [7:0] a;
    if (e[9]) return 8'h00;
    case (e[7:0])
      8'h1C: a = "A"; 8'h32: a = "B"; 8'h21: a = "C"; 8'h23: a = "D"; 8'h24: a = "E";
      8'h2B: a = "F"; 8'h34: a = "G"; 8'h33: a = "H"; 8'h43: a = "I"; 8'h3B: a = "J";
      8'h42: a = "K"; 8'h4B: a = "L"; 8'h3A: a = "M"; 8'h31: a = "N"; 8'h44: a = "O";
      8'h4D: a = "P"; 8'h15: a = "Q"; 8'h2D: a = "R"; 8'h1B: a = "S"; 8'h2C: a = "T";
      8'h3C: a = "U"; 8'h2A: a = "V"; 8'h1D: a = "W"; 8'h22: a = "X"; 8'h35: a = "Y";
      8'h1A: a = "Z";
      8'h45: a = "0"; 8'h16: a = "1"; 8'h1E: a = "2"; 8'h26: a = "3"; 8'h25: a = "4";
      8'h2E: a = "5"; 8'h36: a = "6"; 8'h3D: a = "7"; 8'h3E: a = "8"; 8'h46: a = "9";
      8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
      default: a = 8'h00;
    endcase
    return a;
`else
    return 8'h00;
`endif
  endfunction

  // Model: prefixes are flags, the FIFO is a queue, a prefix is forgotten
  // once TMO or more quiet cycles separate it from the next byte.
  task automatic model_step();
    bit pop, push;
    logic [9:0] ent;
    exp_fe = 1'b0;
    exp_ovf = 1'b0;
    push = 1'b0;
    ent = '0;
    if (rst) begin
      mq.delete();
      m_ext = 1'b0; m_brk = 1'b0; since = 0;
      return;
    end
    pop = (mq.size() != 0) && evt_ready;
    if (rx_tick) begin
      if (since >= TMO) begin m_ext = 1'b0; m_brk = 1'b0; end
      since = 0;
      if (rx_start || rx_data == 8'h00 || rx_data == 8'hFF) begin
        exp_fe = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
      end else if (rx_data == 8'hE0) begin
        m_ext = 1'b1;
      end else if (rx_data == 8'hF0) begin
        m_brk = 1'b1;
      end else begin
        push = 1'b1; ent = {m_ext, m_brk, rx_data};
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end else begin
      since++;
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(ent);
      else exp_ovf = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare process: every cycle, DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp("evt_valid", evt_valid_o, mq.size() != 0);
        cmp("rx_en", rx_en_o, mq.size() != DEPTH);
        cmp("frame_err", frame_err_o, exp_fe);
        cmp("ovf", ovf_o, exp_ovf);
        if (mq.size() != 0) begin
          cmp("evt_code", evt_code_o, mq[0][7:0]);
          cmp("evt_ext", evt_ext_o, mq[0][9]);
          cmp("evt_rel", evt_rel_o, mq[0][8]);
          cmp("evt_ascii", evt_ascii_o, exp_ascii(mq[0]));
        end
      end
    end
  end

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic send(input logic [7:0] d, input logic s);
    rx_tick = 1'b1; rx_data = d; rx_start = s;
    @(posedge clk); #1;
    rx_tick = 1'b0; rx_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop1();
    evt_ready = 1'b1;
    @(posedge clk); #1;
    evt_ready = 1'b0;
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 15);
    if (r < 3) return 8'hE0;
    if (r < 5) return 8'hF0;
    if (r == 5) return 8'h00;
    if (r == 6) return 8'hFF;
    if (r == 7) return 8'($urandom_range(1, 254));
    return pool[$urandom_range(0, 15)];
  endfunction

  initial begin
    logic [7:0] fill [4];
    int gap;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // reset state
    cmp("rst_valid", evt_valid_o, 1'b0);
    cmp("rst_rx_en", rx_en_o, 1'b1);
    cmp("rst_frame_err", frame_err_o, 1'b0);
    cmp("rst_ovf", ovf_o, 1'b0);
    cmp("rst_code", evt_code_o, 8'h00);
    cmp("rst_flags", {evt_ext_o, evt_rel_o}, 2'b00);
    cmp("rst_ascii", evt_ascii_o, 8'h00);

    // single press
    send(8'h1C, 1'b0);
    cmp("1c_valid", evt_valid_o, 1'b1);
    cmp("1c_code", evt_code_o, 8'h1C);
    cmp("1c_flags", {evt_ext_o, evt_rel_o}, 2'b00);
`ifdef PS2_ASCII_EN
    cmp("1c_ascii", evt_ascii_o, 8'h41);
`else
    cmp("1c_ascii", evt_ascii_o, 8'h00);
`endif
    pop1();
    cmp("1c_popped", evt_valid_o, 1'b0);

    // extended release
    send(8'hE0, 1'b0);
    cmp("e0_noevt", evt_valid_o, 1'b0);
    send(8'hF0, 1'b0);
    cmp("f0_noevt", evt_valid_o, 1'b0);
    send(8'h75, 1'b0);
    cmp("e0f075_code", evt_code_o, 8'h75);
    cmp("e0f075_flags", {evt_ext_o, evt_rel_o}, 2'b11);
    pop1();
    cmp("e0f075_single", evt_valid_o, 1'b0);

    // prefix timeout boundaries
    send(8'hF0, 1'b0); idle(TMO); send(8'h1C, 1'b0);
    cmp("tmo_full_rel", evt_rel_o, 1'b0);
    pop1();
    send(8'hF0, 1'b0); idle(TMO - 2); send(8'h1C, 1'b0);
    cmp("tmo_m2_rel", evt_rel_o, 1'b1);
    pop1();
    send(8'hF0, 1'b0); idle(TMO - 1); send(8'h1C, 1'b0);
    cmp("tmo_m1_rel", evt_rel_o, 1'b1);
    pop1();

    // invalid bytes
    send(8'h1C, 1'b1);
    cmp("start_fe", frame_err_o, 1'b1);
    cmp("start_noevt", evt_valid_o, 1'b0);
    idle(1);
    cmp("fe_pulse_end", frame_err_o, 1'b0);
    send(8'hFF, 1'b0);
    cmp("ff_fe", frame_err_o, 1'b1);
    send(8'hE0, 1'b0);
    send(8'h1C, 1'b1);
    send(8'h74, 1'b0);
    cmp("fe_clears_ext", evt_ext_o, 1'b0);
    cmp("fe_clears_code", evt_code_o, 8'h74);
    pop1();

    // full FIFO, overflow, push with pop while full
    send(8'h15, 1'b0); send(8'h1D, 1'b0); send(8'h24, 1'b0); send(8'h2D, 1'b0);
    cmp("full_rx_en", rx_en_o, 1'b0);
    send(8'h2C, 1'b0);
    cmp("full_ovf", ovf_o, 1'b1);
    cmp("full_head", evt_code_o, 8'h15);
    evt_ready = 1'b1;
    send(8'h35, 1'b0);
    evt_ready = 1'b0;
    cmp("pushpop_ovf", ovf_o, 1'b0);
    cmp("pushpop_rx_en", rx_en_o, 1'b0);
    cmp("drain0", evt_code_o, 8'h1D); pop1();
    cmp("drain1", evt_code_o, 8'h24); pop1();
    cmp("drain2", evt_code_o, 8'h2D); pop1();
    cmp("drain3", evt_code_o, 8'h35); pop1();
    cmp("drained", evt_valid_o, 1'b0);

    // pointer wrap over three fills
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        fill[k] = pool[(f * 4 + k + 1) % 16];
        send(fill[k], 1'b0);
      end
      for (int k = 0; k < 4; k++) begin
        cmp("wrap_order", evt_code_o, fill[k]);
        pop1();
      end
    end

    // reset with pending prefix and queued events
    send(8'h11, 1'b0); send(8'h12, 1'b0); send(8'hE0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cmp("mid_rst_valid", evt_valid_o, 1'b0);
    cmp("mid_rst_rx_en", rx_en_o, 1'b1);
    send(8'h74, 1'b0);
    cmp("mid_rst_ext", evt_ext_o, 1'b0);
    cmp("mid_rst_code", evt_code_o, 8'h74);
    pop1();

    // randomized traffic: phase 0 ignores rx_en, phase 1 honours it
    gap = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 2500; c++) begin
        rst = ($urandom_range(0, 499) == 0);
        evt_ready = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
        if (gap == 0 && (ph == 0 || rx_en_o)) begin
          rx_tick = 1'b1;
          rx_data = rand_byte();
          rx_start = ($urandom_range(0, 24) == 0);
          gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 26)) : int'($urandom_range(0, 3));
        end else begin
          rx_tick = 1'b0;
          rx_start = 1'b0;
          if (gap > 0) gap--;
        end
        @(posedge clk); #1;
      end
    end
    rst = 1'b0; rx_tick = 1'b0; rx_start = 1'b0; evt_ready = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
